// File: rtl/mem_stage.sv
// Data-memory access stage: byte/half/word loads and stores over a single-outstanding
// req/ack bus, with upstream stall, access timeout and misalignment trapping.
module mem_stage #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_reg_in,
  input  logic [1:0]  wb_ctrl_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] ALU_Output,
  output logic [31:0] memory_data,
  output logic [4:0]  destination_reg,
  output logic [1:0]  control_signals,
  output logic        pwrite4,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [TW-1:0] cnt_reg, cnt_next;

  // Operands of the access in flight
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  be_reg, be_next;
  logic        we_reg, we_next;
  logic [1:0]  size_reg, size_next;
  logic        uns_reg, uns_next;
  logic [4:0]  dlat_reg, dlat_next;
  logic [1:0]  wlat_reg, wlat_next;

  // MEM_WB-facing outputs
  logic [31:0] alu_out_reg, alu_out_next;
  logic [31:0] mdata_reg, mdata_next;
  logic [4:0]  dest_reg, dest_next;
  logic [1:0]  ctrl_reg, ctrl_next;
  logic        pwrite_reg, pwrite_next;
  logic        aerr_reg, aerr_next;
  logic        berr_reg, berr_next;

  logic        is_mem, misaligned;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;
  logic [31:0] lane;
  logic [31:0] load_ext;

  assign is_mem = in_valid & (mem_read | mem_write);

  always_comb begin
    misaligned = 1'b0;
    in_be      = 4'b1111;
    in_wdata   = store_data;
    case (mem_size)
      2'b00: begin
        in_be    = 4'b0001 << alu_result[1:0];
        in_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        misaligned = alu_result[0];
        in_be      = 4'b0011 << alu_result[1:0];
        in_wdata   = {2{store_data[15:0]}};
      end
      default: misaligned = (alu_result[1:0] != 2'b00);
    endcase
  end

  // Lane select then sign/zero extension of the returned word
  always_comb begin
    lane     = mem_rdata >> {addr_reg[1:0], 3'b000};
    load_ext = lane;
    case (size_reg)
      2'b00:   load_ext = uns_reg ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_ext = uns_reg ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    be_next      = be_reg;
    we_next      = we_reg;
    size_next    = size_reg;
    uns_next     = uns_reg;
    dlat_next    = dlat_reg;
    wlat_next    = wlat_reg;
    alu_out_next = alu_out_reg;
    mdata_next   = mdata_reg;
    dest_next    = dest_reg;
    ctrl_next    = ctrl_reg;
    pwrite_next  = 1'b0;
    aerr_next    = 1'b0;
    berr_next    = 1'b0;
    stall        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          if (!is_mem || misaligned) begin
            pwrite_next  = 1'b1;
            alu_out_next = alu_result;
            mdata_next   = 32'b0;
            dest_next    = dest_reg_in;
            ctrl_next    = is_mem ? 2'b00 : wb_ctrl_in;
            aerr_next    = is_mem;
          end else begin
            stall      = 1'b1;
            state_next = S_WAIT;
            cnt_next   = '0;
            addr_next  = alu_result;
            wdata_next = in_wdata;
            be_next    = in_be;
            we_next    = mem_write;
            size_next  = mem_size;
            uns_next   = mem_unsigned;
            dlat_next  = dest_reg_in;
            wlat_next  = wb_ctrl_in;
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_next   = S_IDLE;
          pwrite_next  = 1'b1;
          alu_out_next = addr_reg;
          mdata_next   = we_reg ? 32'b0 : load_ext;
          dest_next    = dlat_reg;
          ctrl_next    = wlat_reg;
        end else if (cnt_reg == TO_LAST) begin
          // Abort: stall drops so the timed-out instruction is consumed here
          state_next   = S_IDLE;
          pwrite_next  = 1'b1;
          alu_out_next = addr_reg;
          mdata_next   = 32'b0;
          dest_next    = dlat_reg;
          ctrl_next    = 2'b00;
          berr_next    = 1'b1;
        end else begin
          stall    = 1'b1;
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      be_reg      <= '0;
      we_reg      <= 1'b0;
      size_reg    <= '0;
      uns_reg     <= 1'b0;
      dlat_reg    <= '0;
      wlat_reg    <= '0;
      alu_out_reg <= '0;
      mdata_reg   <= '0;
      dest_reg    <= '0;
      ctrl_reg    <= '0;
      pwrite_reg  <= 1'b0;
      aerr_reg    <= 1'b0;
      berr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      be_reg      <= be_next;
      we_reg      <= we_next;
      size_reg    <= size_next;
      uns_reg     <= uns_next;
      dlat_reg    <= dlat_next;
      wlat_reg    <= wlat_next;
      alu_out_reg <= alu_out_next;
      mdata_reg   <= mdata_next;
      dest_reg    <= dest_next;
      ctrl_reg    <= ctrl_next;
      pwrite_reg  <= pwrite_next;
      aerr_reg    <= aerr_next;
      berr_reg    <= berr_next;
    end
  end

  assign mem_req         = (state_reg == S_WAIT);
  assign mem_we          = we_reg;
  assign mem_addr        = {addr_reg[31:2], 2'b00};
  assign mem_be          = be_reg;
  assign mem_wdata       = wdata_reg;
  assign ALU_Output      = alu_out_reg;
  assign memory_data     = mdata_reg;
  assign destination_reg = dest_reg;
  assign control_signals = ctrl_reg;
  assign pwrite4         = pwrite_reg;
  assign align_err       = aerr_reg;
  assign bus_err         = berr_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads/stores, misalignment, timeout and
// mid-access reset, with a scripted ack-delay memory responder.
module tb_mem_stage;

  logic        clk, rst_n;
  logic        in_valid;
  logic [31:0] alu_result, store_data;
  logic [4:0]  dest_reg_in;
  logic [1:0]  wb_ctrl_in;
  logic        mem_read, mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] ALU_Output, memory_data;
  logic [4:0]  destination_reg;
  logic [1:0]  control_signals;
  logic        pwrite4, align_err, bus_err;

  mem_stage #(.TIMEOUT(4), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_result(alu_result),
    .store_data(store_data), .dest_reg_in(dest_reg_in), .wb_ctrl_in(wb_ctrl_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .ALU_Output(ALU_Output), .memory_data(memory_data),
    .destination_reg(destination_reg), .control_signals(control_signals),
    .pwrite4(pwrite4), .align_err(align_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] md;
    logic [4:0]  dest;
    logic [1:0]  ctrl;
    logic        aerr;
    logic        berr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Responder script, set by the stimulus before each access
  logic [31:0] exp_addr, exp_wdata, rdata_val;
  logic [3:0]  exp_be;
  logic        exp_we;
  int          ack_after = 0;
  int          req_cnt = 0;
  int          req_total = 0;
  int          last_req_len = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      req_cnt   = 0;
    end else if (mem_req) begin
      req_cnt++;
      if (req_cnt == 1) req_total++;
      check("bus_we", {31'b0, mem_we}, {31'b0, exp_we});
      check("bus_addr", mem_addr, exp_addr);
      check("bus_be", {28'b0, mem_be}, {28'b0, exp_be});
      check("bus_wdata", mem_wdata, exp_wdata);
      mem_ack   = (ack_after != 0) && (req_cnt == ack_after);
      mem_rdata = mem_ack ? rdata_val : 32'h5A5A_5A5A;
    end else begin
      if (req_cnt != 0) last_req_len = req_cnt;
      req_cnt   = 0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
    end
  end

  // Output monitor: every pwrite4 pops one expected result
  always @(negedge clk) begin
    if (rst_n && pwrite4) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pwrite4", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("alu_out", ALU_Output, mon_e.alu);
        check("mem_data", memory_data, mon_e.md);
        check("dest", {27'b0, destination_reg}, {27'b0, mon_e.dest});
        check("ctrl", {30'b0, control_signals}, {30'b0, mon_e.ctrl});
        check("align_err", {31'b0, align_err}, {31'b0, mon_e.aerr});
        check("bus_err", {31'b0, bus_err}, {31'b0, mon_e.berr});
        $display("txn: alu=%08h md=%08h dest=%0d ctrl=%b aerr=%b berr=%b",
                 ALU_Output, memory_data, destination_reg, control_signals, align_err, bus_err);
      end
    end else if (rst_n && (align_err || bus_err)) begin
      check("stray_err", {30'b0, align_err, bus_err}, 32'd0);
    end
  end

  // Entered at negedge+1; returns at negedge+1 after the result has been checked
  task automatic issue(input string tag, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] dest, input logic [1:0] ctrl,
                       input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] exp_md, input logic aerr, input logic berr,
                       input int exp_stall);
    exp_t e;
    int   stall_cycles;
    bit   done;
    in_valid = 1'b1; alu_result = alu; store_data = sd; dest_reg_in = dest;
    wb_ctrl_in = ctrl; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    e.alu = alu; e.md = exp_md; e.dest = dest;
    e.ctrl = (aerr || berr) ? 2'b00 : ctrl;
    e.aerr = aerr; e.berr = berr;
    sb_q.push_back(e);
    stall_cycles = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (!stall) begin
        done = 1'b1;
      end else begin
        stall_cycles++;
        @(negedge clk); #1;
      end
    end
    if (!done) begin
      check({tag, "_consume_timeout"}, 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk); #1;
      check({tag, "_stall"}, stall_cycles, exp_stall);
    end
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic set_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input int ack_n, input logic [31:0] rd);
    exp_we = we; exp_addr = a; exp_be = be; exp_wdata = wd; ack_after = ack_n; rdata_val = rd;
  endtask

  int prev_req;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0; dest_reg_in = '0;
    wb_ctrl_in = '0; mem_read = 1'b0; mem_write = 1'b0; mem_size = '0; mem_unsigned = 1'b0;
    set_bus(1'b0, 32'h0, 4'h0, 32'h0, 0, 32'h0);
    @(negedge clk); @(negedge clk); #1;
    check("rst_pwrite4", {31'b0, pwrite4}, 32'd0);
    check("rst_alu_out", ALU_Output, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // ADD: latency 1, no stall
    issue("add", 32'h0000_0010, 32'h0, 5'd5, 2'b10, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    // LB / LBU at 0x103, ack on the 4th WAIT cycle (coincides with timeout: ack wins)
    set_bus(1'b0, 32'h100, 4'b1000, 32'h0, 4, 32'h8000_0000);
    issue("lb", 32'h103, 32'h0, 5'd7, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b0, 4);
    issue("lbu", 32'h103, 32'h0, 5'd8, 2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 4);
    // SH at 0x22, immediate ack
    set_bus(1'b1, 32'h20, 4'b1100, 32'hABCD_ABCD, 1, 32'h0);
    issue("sh", 32'h22, 32'h1234_ABCD, 5'd0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    // Misaligned LW: no bus access
    prev_req = req_total;
    issue("lw_mis", 32'h6, 32'h0, 5'd9, 2'b11, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 0);
    check("lw_mis_noreq", req_total, prev_req);
    // Aligned LW right after
    set_bus(1'b0, 32'h8, 4'b1111, 32'h1122_3344, 2, 32'hDEAD_BEEF);
    issue("lw", 32'h8, 32'h1122_3344, 5'd10, 2'b11, 1'b1, 1'b0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2);
    // Halfword loads, both lanes, back to back
    set_bus(1'b0, 32'h0, 4'b1100, 32'h0, 1, 32'h8765_1234);
    issue("lh", 32'h2, 32'h0, 5'd11, 2'b11, 1'b1, 1'b0, 2'b01, 1'b0, 32'hFFFF_8765, 1'b0, 1'b0, 1);
    set_bus(1'b0, 32'h0, 4'b0011, 32'h0, 1, 32'h8765_1234);
    issue("lhu", 32'h0, 32'h0, 5'd12, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1);
    // SB with mem_read also set behaves as a store
    set_bus(1'b1, 32'h0, 4'b0010, 32'hA5A5_A5A5, 3, 32'hFFFF_FFFF);
    issue("sb", 32'h1, 32'h0000_00A5, 5'd0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 3);
    // Timeout: ack never comes
    set_bus(1'b0, 32'h10, 4'b1111, 32'h0, 0, 32'h0);
    issue("lw_to", 32'h10, 32'h0, 5'd13, 2'b11, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, 4);
    check("lw_to_req_len", last_req_len, 32'd4);

    // Reset asserted during WAIT drops everything immediately
    set_bus(1'b0, 32'h20, 4'b1111, 32'h0, 0, 32'h0);
    in_valid = 1'b1; alu_result = 32'h20; dest_reg_in = 5'd14; wb_ctrl_in = 2'b11;
    mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check("pre_rst_req", {31'b0, mem_req}, 32'd1);
    in_valid = 1'b0; mem_read = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'b0, mem_req}, 32'd0);
    check("mid_rst_pwrite4", {31'b0, pwrite4}, 32'd0);
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    issue("add2", 32'h0000_0ABC, 32'h0, 5'd21, 2'b10, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 0);

    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
